// File: rtl/nn_dense_layer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nn_dense_layer: sequential fully-connected layer, Q3.4 weights/activations |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nn_dense_layer #(
  parameter int N_IN = 2,
  parameter int N_OUT = 2,
  parameter logic [N_OUT*N_IN*8-1:0] W = {(N_OUT*N_IN){8'h10}},
  parameter logic [N_OUT*8-1:0] B = {8'hE8, 8'hF8},
  parameter int ACT = 0,
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic signed [7:0]       rd_data,
  output logic                    rd_en,
  output logic [AW-1:0]           rd_addr,
  output logic [N_OUT*8-1:0]      out_data,
  output logic                    ack_layer
);

  localparam int IW = $clog2(N_IN + 1);
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     rd_en_q, rd_en_d;
  logic [AW-1:0]            rd_addr_q, rd_addr_d;
  logic signed [7:0]        x_q [N_IN];
  logic signed [7:0]        x_d [N_IN];
  logic [IW-1:0]            mac_idx_q, mac_idx_d;
  logic [JW-1:0]            neuron_q, neuron_d;
  logic signed [19:0]       acc_q, acc_d;
  logic [N_OUT*8-1:0]       out_q, out_d;
  logic                     ack_q, ack_d;

  logic signed [7:0]        w_sel;
  logic signed [7:0]        x_sel;
  logic [7:0]               b_next;
  logic signed [15:0]       prod;
  logic signed [19:0]       acc_sum;
  logic signed [15:0]       scaled;
  logic [7:0]               act_val;

  // Bias in Q3.4 becomes Q.8 in the accumulator: sign-extend, shift left by 4.
  function automatic logic signed [19:0] bias_q8(input logic [7:0] b);
    return {{8{b[7]}}, b, 4'b0000};
  endfunction

  always_comb begin
    w_sel  = '0;
    x_sel  = '0;
    b_next = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (neuron_q + 1'b1 == JW'(j)) b_next = B[j*8 +: 8];
      for (int i = 0; i < N_IN; i++) begin
        if (neuron_q == JW'(j) && mac_idx_q == IW'(i)) w_sel = W[(j*N_IN+i)*8 +: 8];
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      if (mac_idx_q == IW'(i)) x_sel = x_q[i];
    end
  end

  assign prod    = x_sel * w_sel;
  assign acc_sum = acc_q + {{4{prod[15]}}, prod};
  assign scaled  = acc_q[19:4];

  generate
    if (ACT == 0) begin : g_act_step
      assign act_val = (scaled > 16'sd0) ? 8'd16 : 8'd0;
    end else begin : g_act_relu
      logic [7:0] sat_val;
      always_comb begin
        sat_val = scaled[7:0];
        if (scaled > 16'sd127) sat_val = 8'd127;
        else if (scaled < -16'sd128) sat_val = 8'h80;
      end
      assign act_val = scaled[15] ? 8'd0 : sat_val;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    x_d       = x_q;
    mac_idx_d = mac_idx_q;
    neuron_d  = neuron_q;
    acc_d     = acc_q;
    out_d     = out_q;
    ack_d     = ack_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_READ;
          rd_en_d = 1'b1;
        end
      end
      S_READ: begin
        for (int k = 0; k < N_IN; k++) begin
          if (rd_addr_q == AW'(k)) x_d[k] = rd_data;
        end
        if (rd_addr_q == AW'(N_IN - 1)) begin
          state_d   = S_COMPUTE;
          mac_idx_d = '0;
          neuron_d  = '0;
          acc_d     = bias_q8(B[7:0]);
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        // mac_idx == N_IN marks the activation cycle of the current neuron
        if (mac_idx_q == IW'(N_IN)) begin
          for (int j = 0; j < N_OUT; j++) begin
            if (neuron_q == JW'(j)) out_d[j*8 +: 8] = act_val;
          end
          mac_idx_d = '0;
          if (neuron_q == JW'(N_OUT - 1)) begin
            state_d = S_DONE;
            ack_d   = 1'b1;
          end else begin
            neuron_d = neuron_q + 1'b1;
            acc_d    = bias_q8(b_next);
          end
        end else begin
          acc_d     = acc_sum;
          mac_idx_d = mac_idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      x_q       <= '{default: '0};
      mac_idx_q <= '0;
      neuron_q  <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      x_q       <= x_d;
      mac_idx_q <= mac_idx_d;
      neuron_q  <= neuron_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      ack_q     <= ack_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_data  = out_q;
  assign ack_layer = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_dense_layer.sv
`default_nettype none
// Bench for nn_dense_layer: vector table, corner-case sequences and randomized ReLU layer.
module tb_nn_dense_layer;

  localparam logic [71:0] RND_W = 72'h01807F5A0CCE03F914;
  localparam logic [23:0] RND_B = 24'h64D805;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic def_req, out_req, sat_req, rnd_req, xh_req, xo_req;
  logic [7:0] def_mem [2];
  logic [7:0] out_mem [2];
  logic [7:0] sat_mem [2];
  logic [7:0] rnd_mem [4];
  logic [7:0] xh_mem [2];
  logic [7:0] def_rd_data, out_rd_data, sat_rd_data, rnd_rd_data, xh_rd_data, xo_rd_data;
  logic def_rd_en, out_rd_en, sat_rd_en, rnd_rd_en, xh_rd_en, xo_rd_en;
  logic [0:0] def_rd_addr, out_rd_addr, sat_rd_addr, xh_rd_addr, xo_rd_addr;
  logic [1:0] rnd_rd_addr;
  logic [15:0] def_out, xh_out;
  logic [7:0] out_out, sat_out, xo_out;
  logic [23:0] rnd_out;
  logic def_ack, out_ack, sat_ack, rnd_ack, xh_ack, xo_ack;

  assign def_rd_data = def_mem[def_rd_addr];
  assign out_rd_data = out_mem[out_rd_addr];
  assign sat_rd_data = sat_mem[sat_rd_addr];
  assign rnd_rd_data = rnd_mem[rnd_rd_addr];
  assign xh_rd_data  = xh_mem[xh_rd_addr];
  assign xo_rd_data  = xo_rd_addr[0] ? xh_out[15:8] : xh_out[7:0];
  assign xo_req      = xh_ack;

  nn_dense_layer u_def (
    .clk(clk), .rst(rst), .req(def_req), .rd_data(def_rd_data), .rd_en(def_rd_en),
    .rd_addr(def_rd_addr), .out_data(def_out), .ack_layer(def_ack));

  nn_dense_layer #(.N_IN(2), .N_OUT(1), .W(16'hF010), .B(8'hF8), .ACT(0)) u_out (
    .clk(clk), .rst(rst), .req(out_req), .rd_data(out_rd_data), .rd_en(out_rd_en),
    .rd_addr(out_rd_addr), .out_data(out_out), .ack_layer(out_ack));

  nn_dense_layer #(.N_IN(2), .N_OUT(1), .W(16'h7F7F), .B(8'h00), .ACT(1)) u_sat (
    .clk(clk), .rst(rst), .req(sat_req), .rd_data(sat_rd_data), .rd_en(sat_rd_en),
    .rd_addr(sat_rd_addr), .out_data(sat_out), .ack_layer(sat_ack));

  nn_dense_layer #(.N_IN(3), .N_OUT(3), .W(RND_W), .B(RND_B), .ACT(1)) u_rnd (
    .clk(clk), .rst(rst), .req(rnd_req), .rd_data(rnd_rd_data), .rd_en(rnd_rd_en),
    .rd_addr(rnd_rd_addr), .out_data(rnd_out), .ack_layer(rnd_ack));

  nn_dense_layer u_xh (
    .clk(clk), .rst(rst), .req(xh_req), .rd_data(xh_rd_data), .rd_en(xh_rd_en),
    .rd_addr(xh_rd_addr), .out_data(xh_out), .ack_layer(xh_ack));

  nn_dense_layer #(.N_IN(2), .N_OUT(1), .W(16'hF010), .B(8'hF8), .ACT(0)) u_xo (
    .clk(clk), .rst(rst), .req(xo_req), .rd_data(xo_rd_data), .rd_en(xo_rd_en),
    .rd_addr(xo_rd_addr), .out_data(xo_out), .ack_layer(xo_ack));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // which: 0 default, 1 output layer, 2 saturating ReLU, 3 random ReLU, 4 XOR chain
  function automatic logic get_ack(input int which);
    case (which)
      0: return def_ack;
      1: return out_ack;
      2: return sat_ack;
      3: return rnd_ack;
      default: return xo_ack;
    endcase
  endfunction

  function automatic logic [23:0] get_out(input int which);
    case (which)
      0: return {8'h00, def_out};
      1: return {16'h0000, out_out};
      2: return {16'h0000, sat_out};
      3: return rnd_out;
      default: return {16'h0000, xo_out};
    endcase
  endfunction

  task automatic set_req(input int which, input logic v);
    case (which)
      0: def_req = v;
      1: out_req = v;
      2: sat_req = v;
      3: rnd_req = v;
      default: xh_req = v;
    endcase
  endtask

  task automatic load(input int which, input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    case (which)
      0: begin def_mem[0] = a0; def_mem[1] = a1; end
      1: begin out_mem[0] = a0; out_mem[1] = a1; end
      2: begin sat_mem[0] = a0; sat_mem[1] = a1; end
      3: begin rnd_mem[0] = a0; rnd_mem[1] = a1; rnd_mem[2] = a2; rnd_mem[3] = 8'h00; end
      default: begin xh_mem[0] = a0; xh_mem[1] = a1; end
    endcase
  endtask

  task automatic reset_all();
    @(negedge clk);
    def_req = 0; out_req = 0; sat_req = 0; rnd_req = 0; xh_req = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  // lat = number of edges after E0 at which ack_layer is first seen high; -1 on timeout
  task automatic run(input int which, output int lat);
    lat = -1;
    @(negedge clk);
    set_req(which, 1'b1);
    for (int e = 0; e < 60; e++) begin
      @(negedge clk);
      if (get_ack(which)) begin
        lat = e;
        break;
      end
    end
  endtask

  function automatic logic [23:0] rnd_ref(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    logic [23:0] r;
    int xv [3];
    int acc;
    int s;
    xv[0] = int'($signed(a0));
    xv[1] = int'($signed(a1));
    xv[2] = int'($signed(a2));
    r = '0;
    for (int j = 0; j < 3; j++) begin
      acc = int'($signed(RND_B[j*8 +: 8])) * 16;
      for (int i = 0; i < 3; i++) acc += xv[i] * int'($signed(RND_W[(j*3+i)*8 +: 8]));
      s = acc >>> 4;
      if (s > 127) s = 127;
      if (s < 0) s = 0;
      r[j*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  typedef struct {
    int          which;
    logic [7:0]  in0;
    logic [7:0]  in1;
    logic [23:0] exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs [$];
  int lat;
  int redge;
  int en_cnt;
  int bad;
  logic [7:0] r0, r1, r2;
  logic [23:0] exp_r;

  initial begin
    rst = 1;
    def_req = 0; out_req = 0; sat_req = 0; rnd_req = 0; xh_req = 0;
    load(0, 0, 0, 0); load(1, 0, 0, 0); load(2, 0, 0, 0); load(3, 0, 0, 0); load(4, 0, 0, 0);

    vecs.push_back('{0, 8'd16,  8'd16,  24'h001010, 8});
    vecs.push_back('{0, 8'd16,  8'd0,   24'h000010, 8});
    vecs.push_back('{0, 8'd0,   8'd16,  24'h000010, 8});
    vecs.push_back('{0, 8'd0,   8'd0,   24'h000000, 8});
    vecs.push_back('{1, 8'd16,  8'd0,   24'h000010, 5});
    vecs.push_back('{1, 8'd16,  8'd16,  24'h000000, 5});
    vecs.push_back('{1, 8'd0,   8'd0,   24'h000000, 5});
    vecs.push_back('{1, 8'd0,   8'd16,  24'h000000, 5});
    vecs.push_back('{2, 8'd127, 8'd127, 24'h00007F, 5});
    vecs.push_back('{2, 8'h80,  8'h80,  24'h000000, 5});
    vecs.push_back('{2, 8'd1,   8'd1,   24'h00000F, 5});
    vecs.push_back('{2, 8'd1,   8'hFE,  24'h000000, 5});
    vecs.push_back('{2, 8'd16,  8'hF8,  24'h00003F, 5});
    vecs.push_back('{4, 8'd0,   8'd0,   24'h000000, 14});
    vecs.push_back('{4, 8'd16,  8'd0,   24'h000010, 14});
    vecs.push_back('{4, 8'd0,   8'd16,  24'h000010, 14});
    vecs.push_back('{4, 8'd16,  8'd16,  24'h000000, 14});

    repeat (2) @(negedge clk);
    check("reset_out", def_out, 0);
    check("reset_ack", def_ack, 0);
    check("reset_rd_en", def_rd_en, 0);
    check("reset_rd_addr", def_rd_addr, 0);
    check("reset_all_inst", {out_rd_en, sat_rd_en, rnd_rd_en, xh_rd_en, xo_rd_en,
                             out_ack, sat_ack, rnd_ack, xh_ack, xo_ack}, 0);
    rst = 0;

    // Cycle-accurate read sequence and ack timing on the default layer
    load(0, 16, 16, 0);
    @(negedge clk);
    def_req = 1;
    for (int e = 0; e <= 9; e++) begin
      @(negedge clk);
      if (e == 0) check("seq_e0_en_addr", {def_rd_en, def_rd_addr}, 2'b10);
      if (e == 1) check("seq_e1_en_addr", {def_rd_en, def_rd_addr}, 2'b11);
      if (e == 2) check("seq_e2_en_addr", {def_rd_en, def_rd_addr}, 2'b00);
      if (e == 4) check("seq_e4_out", def_out, 16'h0000);
      if (e == 5) check("seq_e5_out", def_out, 16'h0010);
      if (e == 7) check("seq_e7_ack", def_ack, 0);
      if (e == 8) check("seq_e8_ack", def_ack, 1);
      if (e == 9) check("seq_e9_out", def_out, 16'h1010);
    end

    foreach (vecs[v]) begin
      reset_all();
      load(vecs[v].which, vecs[v].in0, vecs[v].in1, 0);
      run(vecs[v].which, lat);
      check($sformatf("vec%0d_out", v), get_out(vecs[v].which), vecs[v].exp_out);
      check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
    end

    // Reset in the middle of COMPUTE, then a clean recompute
    for (int r = 0; r < 2; r++) begin
      redge = (r == 0) ? 4 : 6;
      reset_all();
      load(0, 16, 16, 0);
      @(negedge clk);
      def_req = 1;
      for (int e = 0; e < redge; e++) @(negedge clk);
      rst = 1;
      def_req = 0;
      @(negedge clk);
      check($sformatf("midrst%0d_out", redge), def_out, 0);
      check($sformatf("midrst%0d_ack_en", redge), {def_ack, def_rd_en, def_rd_addr}, 0);
      rst = 0;
      repeat (3) @(negedge clk);
      check($sformatf("midrst%0d_idle", redge), {def_ack, def_rd_en}, 0);
      load(0, 16, 0, 0);
      run(0, lat);
      check($sformatf("midrst%0d_re_out", redge), def_out, 16'h0010);
      check($sformatf("midrst%0d_re_lat", redge), lat, 8);
    end

    // req still high in DONE: no restart, outputs held
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!def_ack || def_out !== 16'h0010 || def_rd_en) bad++;
    end
    check("done_hold_bad_cycles", bad, 0);

    // req toggled every cycle: exactly one computation
    reset_all();
    load(0, 0, 16, 0);
    @(negedge clk);
    def_req = 1;
    en_cnt = 0;
    lat = -1;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      if (def_rd_en) en_cnt++;
      if (def_ack && lat < 0) lat = e;
      def_req = ~def_req;
    end
    check("toggle_rd_en_cycles", en_cnt, 2);
    check("toggle_lat", lat, 8);
    check("toggle_out", def_out, 16'h0010);
    check("toggle_ack", def_ack, 1);

    // Randomized activations on a 3x3 ReLU layer
    for (int it = 0; it < 20; it++) begin
      reset_all();
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      load(3, r0, r1, r2);
      exp_r = rnd_ref(r0, r1, r2);
      run(3, lat);
      check($sformatf("rnd%0d_out", it), rnd_out, exp_r);
      check($sformatf("rnd%0d_lat", it), lat, 15);
    end

    reset_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
